// File: rtl/reg_bus_hub_if.sv
// Register-bus bundle: request side from the frame address decoder plus the broadcast/ack side to N register slaves.
// The hub uses the master modport (it masters the slave bus); the surrounding system uses the slave modport.
interface reg_bus_hub_if #(
    parameter int N_SLAVES = 3,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
);
    logic                         m_valid;
    logic [ADDR_W-1:0]            m_address;
    logic [DATA_W-1:0]            m_data;
    logic                         m_ready;
    logic                         m_done;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_rdata_valid;
    logic [1:0]                   m_err;
    logic [IDX_W-1:0]             m_slave;
    logic                         s_valid;
    logic [ADDR_W-1:0]            s_address;
    logic [DATA_W-1:0]            s_data;
    logic [N_SLAVES-1:0]          s_ack;
    logic [N_SLAVES*DATA_W-1:0]   s_data_out;
    logic [N_SLAVES-1:0]          s_data_out_valid;

    modport master (
        input  m_valid, m_address, m_data, s_ack, s_data_out, s_data_out_valid,
        output m_ready, m_done, m_rdata, m_rdata_valid, m_err, m_slave,
               s_valid, s_address, s_data
    );

    modport slave (
        output m_valid, m_address, m_data, s_ack, s_data_out, s_data_out_valid,
        input  m_ready, m_done, m_rdata, m_rdata_valid, m_err, m_slave,
               s_valid, s_address, s_data
    );
endinterface

// File: rtl/reg_bus_hub.sv
// Register-bus hub: broadcasts one request to N slaves, waits up to TIMEOUT cycles for an ack, muxes the reply; done 2+ cycles after accept.
// Backpressure: m_ready is low from acceptance through the done pulse; m_valid seen while busy is dropped, nothing is queued.
module reg_bus_hub #(
    parameter int N_SLAVES = 3,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int TIMEOUT  = 15,
    parameter int IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_bus_hub_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [N_SLAVES-1:0] ack_hit;
    logic [DATA_W-1:0]   ack_rdata;
    logic [IDX_W-1:0]    ack_idx;
    logic                ack_multi;

    assign ack_hit   = bus.s_ack & bus.s_data_out_valid;
    assign ack_multi = (bus.s_ack & (bus.s_ack - N_SLAVES'(1))) != '0;

    // Descending scan so the last write leaves the lowest acking index.
    always_comb begin
        ack_rdata = '0;
        ack_idx   = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (ack_hit[i]) begin
                ack_rdata = ack_rdata | bus.s_data_out[i*DATA_W +: DATA_W];
            end
            if (bus.s_ack[i]) begin
                ack_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            bus.m_ready       <= 1'b1;
            bus.m_done        <= 1'b0;
            bus.m_rdata       <= '0;
            bus.m_rdata_valid <= 1'b0;
            bus.m_err         <= 2'b00;
            bus.m_slave       <= '0;
            bus.s_valid       <= 1'b0;
            bus.s_address     <= '0;
            bus.s_data        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m_valid) begin
                        bus.s_address <= bus.m_address;
                        bus.s_data    <= bus.m_data;
                        wait_cnt      <= '0;
                        bus.m_ready   <= 1'b0;
                        bus.s_valid   <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    // An ack in the final wait cycle still completes normally.
                    if (|bus.s_ack) begin
                        bus.m_rdata       <= ack_rdata;
                        bus.m_rdata_valid <= |ack_hit;
                        bus.m_slave       <= ack_idx;
                        bus.m_err         <= ack_multi ? 2'b10 : 2'b00;
                        bus.s_valid       <= 1'b0;
                        bus.m_done        <= 1'b1;
                        state             <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        bus.m_rdata       <= '0;
                        bus.m_rdata_valid <= 1'b0;
                        bus.m_slave       <= '0;
                        bus.m_err         <= 2'b01;
                        bus.s_valid       <= 1'b0;
                        bus.m_done        <= 1'b1;
                        state             <= DONE;
                    end
                end
                DONE: begin
                    bus.m_done  <= 1'b0;
                    bus.m_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bus_hub.sv
// Bench for reg_bus_hub: directed vector table, randomized transactions against a reference model,
// reset mid-transaction, and a widened (5 slave, 8-bit data) instance.
module tb_reg_bus_hub;
    localparam int N  = 3;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    reg_bus_hub_if #(.N_SLAVES(3), .ADDR_W(4), .DATA_W(4), .IDX_W(2)) bus ();
    reg_bus_hub #(.N_SLAVES(3), .ADDR_W(4), .DATA_W(4), .TIMEOUT(TO), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    reg_bus_hub_if #(.N_SLAVES(5), .ADDR_W(4), .DATA_W(8), .IDX_W(3)) bus2 ();
    reg_bus_hub #(.N_SLAVES(5), .ADDR_W(4), .DATA_W(8), .TIMEOUT(TO), .IDX_W(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  data;
        int          delay;
        logic [2:0]  ack;
        logic [2:0]  dv;
        logic [11:0] dout;
        bit          drop;
        logic [3:0]  e_rdata;
        logic        e_rv;
        logic [1:0]  e_err;
        logic [1:0]  e_slave;
        int          e_done;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: derive the transaction outcome directly from the ack pattern and its timing.
    function automatic void model(input vec_t v, output logic [3:0] rdata, output logic rv,
                                  output logic [1:0] err, output logic [1:0] slv, output int done);
        int k;
        rdata = '0;
        rv    = 1'b0;
        err   = 2'b00;
        slv   = '0;
        if (v.ack == 3'b000 || v.delay > TO) begin
            err  = 2'b01;
            done = TO + 1;
            return;
        end
        done = v.delay + 1;
        if ($countones(v.ack) > 1) err = 2'b10;
        k = 0;
        while (!v.ack[k]) k++;
        slv = 2'(k);
        for (int i = 0; i < N; i++) begin
            if (v.ack[i] && v.dv[i]) begin
                rdata = rdata | 4'(v.dout >> (4 * i));
                rv    = 1'b1;
            end
        end
    endfunction

    task automatic run_txn(input vec_t v, output logic [3:0] rdata, output logic rv,
                           output logic [1:0] err, output logic [1:0] slv,
                           output int done_cyc, output int svcnt);
        int guard;
        guard = 0;
        while (!bus.m_ready && guard < 20) begin
            step();
            guard++;
        end
        check("ready_before_req", bus.m_ready, 1);
        bus.m_valid   = 1'b1;
        bus.m_address = v.addr;
        bus.m_data    = v.data;
        step();
        bus.m_valid   = 1'b0;
        bus.m_address = ~v.addr;
        bus.m_data    = ~v.data;
        check("s_address_latched", bus.s_address, v.addr);
        check("s_data_latched", bus.s_data, v.data);
        done_cyc = 1;
        svcnt    = 0;
        while (!bus.m_done && done_cyc < 40) begin
            if (bus.s_valid) svcnt++;
            bus.s_ack            = (done_cyc == v.delay) ? v.ack : 3'b000;
            bus.s_data_out_valid = v.dv;
            bus.s_data_out       = v.dout;
            bus.m_valid          = v.drop && (done_cyc == 2);
            step();
            done_cyc++;
        end
        bus.s_ack   = '0;
        bus.m_valid = 1'b0;
        check("s_valid_low_at_done", bus.s_valid, 0);
        check("m_ready_low_at_done", bus.m_ready, 0);
        check("s_address_held", bus.s_address, v.addr);
        rdata = bus.m_rdata;
        rv    = bus.m_rdata_valid;
        err   = bus.m_err;
        slv   = bus.m_slave;
        step();
        check("m_done_one_cycle", bus.m_done, 0);
        check("m_ready_after_done", bus.m_ready, 1);
        check("m_rdata_hold", bus.m_rdata, rdata);
    endtask

    initial begin
        logic [3:0] g_rdata, m_rdata;
        logic       g_rv, m_rv;
        logic [1:0] g_err, m_err, g_slv, m_slv;
        int         g_done, m_done, svcnt, cnt_done, cnt_sv;
        vec_t       r;

        //              addr  data delay ack     dv      dout     drop rdata rv err    slave done
        vecs[0] = '{4'h2, 4'h5, 1,  3'b010, 3'b010, 12'h0A0, 0, 4'hA, 1, 2'b00, 2'd1, 2};
        vecs[1] = '{4'h7, 4'h1, 1,  3'b000, 3'b111, 12'hFFF, 0, 4'h0, 0, 2'b01, 2'd0, 16};
        vecs[2] = '{4'h3, 4'h9, 1,  3'b101, 3'b101, 12'h803, 0, 4'hB, 1, 2'b10, 2'd0, 2};
        vecs[3] = '{4'h4, 4'h2, 1,  3'b100, 3'b000, 12'h700, 0, 4'h0, 0, 2'b00, 2'd2, 2};
        vecs[4] = '{4'hE, 4'h6, 4,  3'b001, 3'b001, 12'h006, 1, 4'h6, 1, 2'b00, 2'd0, 5};
        vecs[5] = '{4'h1, 4'hD, 15, 3'b100, 3'b100, 12'h900, 0, 4'h9, 1, 2'b00, 2'd2, 16};
        vecs[6] = '{4'h5, 4'h8, 2,  3'b010, 3'b101, 12'hF5F, 0, 4'h0, 0, 2'b00, 2'd1, 3};
        vecs[7] = '{4'hA, 4'hC, 16, 3'b011, 3'b011, 12'h0FF, 0, 4'h0, 0, 2'b01, 2'd0, 16};

        bus.m_valid = 0; bus.m_address = 0; bus.m_data = 0;
        bus.s_ack = 0; bus.s_data_out = 0; bus.s_data_out_valid = 0;
        bus2.m_valid = 0; bus2.m_address = 0; bus2.m_data = 0;
        bus2.s_ack = 0; bus2.s_data_out = 0; bus2.s_data_out_valid = 0;

        rst = 1'b0;
        step();
        step();
        check("rst_m_ready", bus.m_ready, 1);
        check("rst_s_valid", bus.s_valid, 0);
        check("rst_m_done", bus.m_done, 0);
        check("rst_m_rdata", bus.m_rdata, 0);
        check("rst_m_rdata_valid", bus.m_rdata_valid, 0);
        check("rst_m_err", bus.m_err, 0);
        check("rst_m_slave", bus.m_slave, 0);
        check("rst_s_address", bus.s_address, 0);
        check("rst_s_data", bus.s_data, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], g_rdata, g_rv, g_err, g_slv, g_done, svcnt);
            check("vec_done_cycle", g_done, vecs[i].e_done);
            check("vec_s_valid_cycles", svcnt, vecs[i].e_done - 1);
            check("vec_rdata", g_rdata, vecs[i].e_rdata);
            check("vec_rdata_valid", g_rv, vecs[i].e_rv);
            check("vec_err", g_err, vecs[i].e_err);
            check("vec_slave", g_slv, vecs[i].e_slave);
        end

        for (int t = 0; t < 40; t++) begin
            r.addr  = 4'($urandom);
            r.data  = 4'($urandom);
            r.delay = $urandom_range(1, TO + 2);
            r.ack   = ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom);
            r.dv    = 3'($urandom);
            r.dout  = 12'($urandom);
            r.drop  = ($urandom_range(0, 3) == 0);
            model(r, m_rdata, m_rv, m_err, m_slv, m_done);
            run_txn(r, g_rdata, g_rv, g_err, g_slv, g_done, svcnt);
            check("rand_done_cycle", g_done, m_done);
            check("rand_s_valid_cycles", svcnt, m_done - 1);
            check("rand_rdata", g_rdata, m_rdata);
            check("rand_rdata_valid", g_rv, m_rv);
            check("rand_err", g_err, m_err);
            check("rand_slave", g_slv, m_slv);
        end

        // Reset while a request is outstanding.
        bus.m_valid   = 1'b1;
        bus.m_address = 4'hC;
        bus.m_data    = 4'h3;
        step();
        bus.m_valid = 1'b0;
        step();
        check("pre_rst_s_valid", bus.s_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_s_valid", bus.s_valid, 0);
        check("mid_rst_m_ready", bus.m_ready, 1);
        check("mid_rst_m_done", bus.m_done, 0);
        check("mid_rst_m_rdata", bus.m_rdata, 0);
        check("mid_rst_m_rdata_valid", bus.m_rdata_valid, 0);
        check("mid_rst_m_err", bus.m_err, 0);
        check("mid_rst_m_slave", bus.m_slave, 0);
        check("mid_rst_s_address", bus.s_address, 0);
        check("mid_rst_s_data", bus.s_data, 0);
        step();
        rst = 1'b1;
        cnt_done = 0;
        cnt_sv   = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.m_done) cnt_done++;
            if (bus.s_valid) cnt_sv++;
        end
        check("post_rst_no_done", cnt_done, 0);
        check("post_rst_no_s_valid", cnt_sv, 0);

        // Widened instance: slave 4 answers alone, then slaves 1 and 4 together.
        bus2.m_valid   = 1'b1;
        bus2.m_address = 4'h9;
        bus2.m_data    = 8'h5A;
        step();
        bus2.m_valid = 1'b0;
        check("w_s_valid", bus2.s_valid, 1);
        check("w_s_address", bus2.s_address, 4'h9);
        check("w_s_data", bus2.s_data, 8'h5A);
        bus2.s_ack            = 5'b10000;
        bus2.s_data_out_valid = 5'b10001;
        bus2.s_data_out       = 40'hC3_11_22_33_44;
        step();
        bus2.s_ack = '0;
        check("w_m_done", bus2.m_done, 1);
        check("w_m_slave", bus2.m_slave, 4);
        check("w_m_rdata", bus2.m_rdata, 8'hC3);
        check("w_m_rdata_valid", bus2.m_rdata_valid, 1);
        check("w_m_err", bus2.m_err, 0);
        step();
        check("w_m_ready", bus2.m_ready, 1);
        bus2.m_valid   = 1'b1;
        bus2.m_address = 4'h6;
        step();
        bus2.m_valid          = 1'b0;
        bus2.s_ack            = 5'b10010;
        bus2.s_data_out_valid = 5'b10010;
        bus2.s_data_out       = 40'hC3_00_00_0C_00;
        step();
        bus2.s_ack = '0;
        check("w2_m_done", bus2.m_done, 1);
        check("w2_m_slave", bus2.m_slave, 1);
        check("w2_m_rdata", bus2.m_rdata, 8'hCF);
        check("w2_m_err", bus2.m_err, 2'b10);
        check("w2_s_address", bus2.s_address, 4'h6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
